// File: rtl/compare_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// Relations, FSM states and the seed-decode helper live here.
package compare_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_LT = 2'd1,
        REL_GT = 2'd2
    } rel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Seed is {eq, lt, gt}. GT wins over LT, and anything else, including all-zero, means EQ.
    function automatic rel_t decode_seed(input logic [2:0] seed);
        casez (seed)
            3'b??1:  return REL_GT;
            3'b?10:  return REL_LT;
            default: return REL_EQ;
        endcase
    endfunction

endpackage

// File: rtl/compare_digit.sv
// One digit step of the LSB-first comparison: a differing digit overrides
// the relation carried in from lower digits, and an equal digit passes it through.
module compare_digit
    import compare_pkg::*;
#(
    parameter int SLICE_W = 2
) (
    input  logic [SLICE_W-1:0] a_dig,
    input  logic [SLICE_W-1:0] b_dig,
    input  logic [1:0]         rel_in,
    output logic [1:0]         rel_out
);

    always_comb begin
        // NOTE: assign the default first so every path drives rel_out and no latch is inferred.
        rel_out = rel_in;
        if (a_dig > b_dig) begin
            rel_out = REL_GT;
        end else if (a_dig < b_dig) begin
            rel_out = REL_LT;
        end
    end

endmodule

// File: rtl/compare8_serial_lsb.sv
// Iterative 8-bit magnitude comparator. It scans SLICE_W-bit digits LSB-first
// and can be chained from a lower-order stage through the ieq/ilt/igt seed.
module compare8_serial_lsb
    import compare_pkg::*;
#(
    parameter int SLICE_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ieq,
    input  logic       ilt,
    input  logic       igt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       oeq,
    output logic       olt,
    output logic       ogt,
    output logic       busy
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    rel_t                rel_q;
    logic [1:0]          rel_next;
    logic [CNT_W-1:0]    cnt;
    logic [SLICE_W-1:0]  a_dig;
    logic [SLICE_W-1:0]  b_dig;
    logic                accept;
    logic                last_digit;

    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt == CNT_W'(N - 1));
    assign a_dig      = a_q[cnt*SLICE_W +: SLICE_W];
    assign b_dig      = b_q[cnt*SLICE_W +: SLICE_W];

    compare_digit #(
        .SLICE_W (SLICE_W)
    ) u_digit (
        .a_dig   (a_dig),
        .b_dig   (b_dig),
        .rel_in  (rel_q),
        .rel_out (rel_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The result registers load only when the last digit resolves, so they hold between transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            rel_q <= REL_EQ;
            cnt   <= '0;
            oeq   <= 1'b0;
            olt   <= 1'b0;
            ogt   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            rel_q <= decode_seed({ieq, ilt, igt});
            cnt   <= '0;
        end else if (state == BUSY) begin
            rel_q <= rel_t'(rel_next);
            if (last_digit) begin
                oeq <= (rel_next == REL_EQ);
                olt <= (rel_next == REL_LT);
                ogt <= (rel_next == REL_GT);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_compare8_serial_lsb.sv
// Self-checking bench for compare8_serial_lsb at SLICE_W=2.
// A whole-word model checks each cycle, and directed vectors add literal expectations.
module tb_compare8_serial_lsb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       ieq = 1'b0;
    logic       ilt = 1'b0;
    logic       igt = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       oeq;
    logic       olt;
    logic       ogt;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: one transaction in flight at most.
    bit         pending  = 1'b0;
    int         acc_cyc  = 0;
    logic [2:0] exp_res  = 3'b000;
    logic [2:0] last_res = 3'b000;
    int         done_cyc[$];

    compare8_serial_lsb #(
        .SLICE_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ieq       (ieq),
        .ilt       (ilt),
        .igt       (igt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .oeq       (oeq),
        .olt       (olt),
        .ogt       (ogt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result as {eq, lt, gt}. A full-word unsigned compare decides, and only a tie falls back to the seed.
    function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic l, input logic g);
        if (x > y)      return 3'b001;
        else if (x < y) return 3'b010;
        else if (g)     return 3'b001;
        else if (l)     return 3'b010;
        else            return 3'b100;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic exp_ov;
        if (rst) begin
            pending  = 1'b0;
            last_res = 3'b000;
        end
        exp_ov = pending && (cyc >= acc_cyc + 4);
        check("handshake", 32'({in_ready, out_valid, busy}), 32'({!pending, exp_ov, pending}));
        check("result", 32'({oeq, olt, ogt}), 32'(exp_ov ? exp_res : last_res));
        if (!rst) begin
            if (exp_ov && out_ready) begin
                pending  = 1'b0;
                last_res = exp_res;
                done_cyc.push_back(cyc + 1);
            end else if (!pending && in_valid) begin
                pending = 1'b1;
                acc_cyc = cyc + 1;
                exp_res = model(a, b, ilt, igt);
            end
        end
    end

    task automatic send(input logic [7:0] av, input logic [7:0] bv,
                        input logic e, input logic l, input logic g);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", 32'(in_ready), 32'(1));
        a = av; b = bv; ieq = e; ilt = l; igt = g;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        {ieq, ilt, igt} = 3'($urandom);
    endtask

    // Call right after send: latency is counted in edges from the acceptance edge.
    task automatic wait_result(input string name, input logic [2:0] exp, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'(exp_lat));
        check({name, "_res"}, 32'({oeq, olt, ogt}), 32'(exp));
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [7:0] av;
        logic [7:0] bv;
        logic [2:0] seed;   // {eq, lt, gt}
        logic [2:0] res;    // {eq, lt, gt}
    } vec_t;

    vec_t dir_vecs[4] = '{
        '{8'h00, 8'hFF, 3'b000, 3'b010},
        '{8'hFF, 8'hFF, 3'b000, 3'b100},
        '{8'h40, 8'h3F, 3'b100, 3'b001},
        '{8'hA5, 8'hA6, 3'b001, 3'b010}
    };

    vec_t b2b_vecs[4] = '{
        '{8'h10, 8'h20, 3'b100, 3'b010},
        '{8'h99, 8'h98, 3'b100, 3'b001},
        '{8'h77, 8'h77, 3'b010, 3'b010},
        '{8'hC3, 8'hC3, 3'b100, 3'b100}
    };

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // The very first edge after reset release accepts.
        send(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0);
        wait_result("eq5a", 3'b100, 4);

        // Low digits say LT, and the top digit flips the result to GT.
        send(8'h81, 8'h7F, 1'b1, 1'b0, 1'b0);
        wait_result("gt81", 3'b001, 4);

        send(8'h12, 8'h12, 1'b0, 1'b1, 1'b0);
        wait_result("seed_lt", 3'b010, 4);
        send(8'h12, 8'h12, 1'b1, 1'b1, 1'b1);
        wait_result("seed_all", 3'b001, 4);

        check("model_81_7f", 32'(model(8'h81, 8'h7F, 1'b0, 1'b0)), 32'(3'b001));
        check("model_00_01", 32'(model(8'h00, 8'h01, 1'b0, 1'b1)), 32'(3'b010));
        check("model_tie_lt", 32'(model(8'h12, 8'h12, 1'b1, 1'b0)), 32'(3'b010));

        foreach (dir_vecs[i]) begin
            send(dir_vecs[i].av, dir_vecs[i].bv,
                 dir_vecs[i].seed[2], dir_vecs[i].seed[1], dir_vecs[i].seed[0]);
            wait_result($sformatf("dir%0d", i), dir_vecs[i].res, 4);
        end

        // Consumer stalls for 5 clocks while in_valid pulses.
        out_ready = 1'b0;
        send(8'h33, 8'h31, 1'b1, 1'b0, 1'b0);
        wait_result("stall", 3'b001, 4);
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("stall_ov", 32'(out_valid), 32'(1));
            check("stall_ir", 32'(in_ready), 32'(0));
            check("stall_res", 32'({oeq, olt, ogt}), 32'(3'b001));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_ov", 32'(out_valid), 32'(0));
        check("release_ir", 32'(in_ready), 32'(1));
        check("release_busy", 32'(busy), 32'(0));

        // Reset during the second BUSY clock drops the pending result.
        send(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_ov", 32'(out_valid), 32'(0));
        check("abort_ir", 32'(in_ready), 32'(1));
        check("abort_res", 32'({oeq, olt, ogt}), 32'(3'b000));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'({out_valid, oeq, olt, ogt}), 32'(4'b0000));
        end
        send(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        wait_result("post_rst", 3'b010, 4);

        // Back-to-back with in_valid held high.
        done_cyc.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        foreach (b2b_vecs[i]) begin
            int n = 0;
            a   = b2b_vecs[i].av;
            b   = b2b_vecs[i].bv;
            {ieq, ilt, igt} = b2b_vecs[i].seed;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check("b2b_ready", 32'(in_ready), 32'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        begin
            int n = 0;
            while (done_cyc.size() < 4 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("b2b_count", 32'(done_cyc.size()), 32'(4));
        for (int i = 1; i < done_cyc.size(); i++) begin
            check("b2b_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(6));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
